// File: rtl/pri_en_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pri_en_pkg                                              |
// | Brief  : Shared widths and types for the 16-bit priority encoder |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package pri_en_pkg;

    localparam int DATA_W  = 16;
    localparam int IDX_W   = 4;
    localparam int GROUP_W = 4;
    localparam int N_GROUP = DATA_W / GROUP_W;

    typedef logic [DATA_W-1:0] req_t;
    typedef logic [IDX_W-1:0]  idx_t;

endpackage
`default_nettype wire

// File: rtl/pri_en16_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pri_en16_if                                             |
// | Brief  : Request/result bundle; grant exists with                |
// |          PRI_EN16_ONEHOT_EN.                                     |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
interface pri_en16_if;
    import pri_en_pkg::*;

    req_t inp;
    idx_t which;
    logic hit;
    idx_t which_q;
    logic hit_q;
`ifdef PRI_EN16_ONEHOT_EN
    req_t grant;

    modport master (output inp, input which, hit, which_q, hit_q, grant);
    modport slave  (input inp, output which, hit, which_q, hit_q, grant);
`else
    modport master (output inp, input which, hit, which_q, hit_q);
    modport slave  (input inp, output which, hit, which_q, hit_q);
`endif

endinterface
`default_nettype wire

// File: rtl/pri_en4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pri_en4                                                 |
// | Brief  : 4-bit priority encoder, highest set bit wins            |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module pri_en4 (
    input  wire logic [3:0] d,
    output logic      [1:0] idx,
    output logic            hit
);

    always_comb begin
        idx = 2'd0;
        if      (d[3]) idx = 2'd3;
        else if (d[2]) idx = 2'd2;
        else if (d[1]) idx = 2'd1;
        hit = |d;
    end

endmodule
`default_nettype wire

// File: rtl/pri_en16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pri_en16                                                |
// | Brief  : 16-bit priority encoder, two-level tree + registered    |
// |          copy. Optional one-hot grant: PRI_EN16_ONEHOT_EN.       |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module pri_en16
    import pri_en_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    pri_en16_if.slave  bus
);

    logic [N_GROUP-1:0] w_ghit;
    logic [1:0]         w_gidx [N_GROUP];
    logic [1:0]         w_sel;
    logic               w_hit;
    idx_t               w_which;
    idx_t               r_which_q;
    logic               r_hit_q;

    generate
        for (genvar g = 0; g < N_GROUP; g++) begin : g_group
            pri_en4 u_grp (
                .d   (bus.inp[g*GROUP_W +: GROUP_W]),
                .idx (w_gidx[g]),
                .hit (w_ghit[g])
            );
        end
    endgenerate

    pri_en4 u_sel (
        .d   (w_ghit),
        .idx (w_sel),
        .hit (w_hit)
    );

    // With no request the select is 0 and group 0 is empty, so which is 0.
    assign w_which   = {w_sel, w_gidx[w_sel]};
    assign bus.which = w_which;
    assign bus.hit   = w_hit;

`ifdef PRI_EN16_ONEHOT_EN
    assign bus.grant = w_hit ? (req_t'(1) << w_which) : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_which_q <= '0;
            r_hit_q   <= 1'b0;
        end else begin
            r_which_q <= w_which;
            r_hit_q   <= w_hit;
        end
    end

    assign bus.which_q = r_which_q;
    assign bus.hit_q   = r_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_pri_en16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_pri_en16                                             |
// | Brief  : Self-checking bench for pri_en16 against a scan model   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_pri_en16;
    import pri_en_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    pri_en16_if bus ();

    pri_en16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: scan from the top for the first set bit.
    function automatic int ref_idx(input logic [15:0] v);
        for (int p = 15; p >= 0; p--)
            if (v[p]) return p;
        return 0;
    endfunction

    // Apply v, check combinational outputs, then the registered copy after an edge.
    task automatic apply(input string tag, input logic [15:0] v);
        int  e_idx;
        logic e_hit;
        @(negedge clk);
        bus.inp = v;
        #1;
        e_hit = (v != 16'h0);
        e_idx = e_hit ? ref_idx(v) : 0;
        check({tag, ".hit"},   32'(bus.hit),   32'(e_hit));
        check({tag, ".which"}, 32'(bus.which), 32'(e_idx));
`ifdef PRI_EN16_ONEHOT_EN
        check({tag, ".grant"}, 32'(bus.grant), e_hit ? (32'd1 << e_idx) : 32'd0);
`endif
        @(posedge clk);
        #1;
        check({tag, ".hit_q"},   32'(bus.hit_q),   32'(e_hit));
        check({tag, ".which_q"}, 32'(bus.which_q), 32'(e_idx));
    endtask

    initial begin
        logic [15:0] v;
        rst_n   = 1'b0;
        bus.inp = 16'h8001;
        #2;
        check("rst.hit_q",   32'(bus.hit_q),   32'd0);
        check("rst.which_q", 32'(bus.which_q), 32'd0);
        check("rst.comb_which", 32'(bus.which), 32'd15);
        @(posedge clk);
        #1;
        check("rst_hold.hit_q", 32'(bus.hit_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("zero",  16'h0000);
        apply("h8001", 16'h8001);
        apply("h0030", 16'h0030);
        apply("h0001", 16'h0001);
        apply("hffff", 16'hffff);
        for (int p = 0; p < 16; p++)
            apply($sformatf("walk%0d", p), 16'h1 << p);
        for (int i = 0; i < 120; i++) begin
            v = 16'($urandom) >> $urandom_range(0, 15);
            apply($sformatf("rnd%0d", i), v);
        end

        // Asynchronous reset between edges while holding which_q=9.
        apply("pre_rst", 16'h0200);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.hit_q",   32'(bus.hit_q),   32'd0);
        check("arst.which_q", 32'(bus.which_q), 32'd0);
        check("arst.which",   32'(bus.which),   32'd9);
        check("arst.hit",     32'(bus.hit),     32'd1);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_rel.hit_q", 32'(bus.hit_q), 32'd0);
        @(posedge clk);
        #1;
        check("first_edge.which_q", 32'(bus.which_q), 32'd9);
        check("first_edge.hit_q",   32'(bus.hit_q),   32'd1);

        if (errors == 0) $display("PASS");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pri_en16.md
PRI_EN16 -- requirements
Module: pri_en16

Interface
REQ-001 Parameters: none; data width is fixed at 16 bits and index width at 4 bits.
REQ-002 clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inp  input  16  request vector; bit p set means request at priority p, with higher index taking precedence.
REQ-005 which  output  4  combinational index of the highest set bit of inp.
REQ-006 hit  output  1  combinational; 1 when inp is nonzero.
REQ-007 which_q  output  4  registered copy of which.
REQ-008 hit_q  output  1  registered copy of hit.
REQ-009 grant  output  16  one-hot of the winning bit; present only when PRI_EN16_ONEHOT_EN is defined.

Function
REQ-010 hit SHALL equal the OR-reduction of inp, with no clock dependency and settling within the same delta/cycle.
REQ-011 When hit=1, which SHALL equal the largest p such that inp[p]=1; lower set bits SHALL be ignored.
REQ-012 When hit=0 (inp=0), which SHALL be 4'd0; consumers qualify which with hit.
REQ-013 inp=16'h0001 SHALL give which=0, hit=1, which must be distinguishable from the no-request case only via hit.
REQ-014 inp with bit 15 set SHALL give which=15 regardless of all other bits.
REQ-015 which_q/hit_q SHALL capture which/hit on every rising clk edge, giving 1-cycle latency with no enable and no stall.
REQ-016 The combinational path SHALL be pure logic: no latches, and no X on the outputs for any fully-defined inp.
REQ-017 The encoding SHALL be a 2-level tree: four 4-bit groups each produce a local hit and 2-bit index; the top level selects the highest hitting group, and which = {group index, local index}.

Reset
REQ-018 While rst_n=0: which_q=0 and hit_q=0 immediately (asynchronous), independent of clk.
REQ-019 On rst_n deassertion, the first rising clk edge SHALL load current which/hit.
REQ-020 Combinational which/hit (and grant) SHALL be unaffected by rst_n.
REQ-021 Reset asserted mid-operation SHALL clear the registered outputs at once; there is no other state.

Configuration
REQ-022 Macro PRI_EN16_ONEHOT_EN: when defined, the grant port exists and is combinational, grant = 1<<which when hit=1, else 16'h0000.
REQ-023 Without PRI_EN16_ONEHOT_EN, the grant port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Shared package pri_en_pkg SHALL hold the constants DATA_W=16, IDX_W=4 and GROUP_W=4, plus typedefs for the request vector and index.
REQ-025 Sub-module pri_en4 (4-bit input; outputs 2-bit index of the highest set bit and a hit) SHALL be instantiated five times: four groups and one group-select.

Verification
REQ-026 inp=16'h0000 -> hit=0, which=0; after a clk edge, hit_q=0 and which_q=0; grant=0 if enabled.
REQ-027 inp=16'h8001 -> which=15, hit=1; grant=16'h8000 if enabled.
REQ-028 inp=16'h0030 -> which=5, hit=1; the next edge gives which_q=5, hit_q=1.
REQ-029 Walking single bit p=0..15 -> which=p, hit=1 for every p.
REQ-030 At least 100 random vectors, each a random 16-bit value right-shifted by a random 0..15 -> hit equals (inp!=0), and when hit=1, which equals the scan-derived highest set bit; the run prints PASS on no mismatch.
REQ-031 With registered outputs at hit_q=1, which_q=9, drive rst_n low between edges -> which_q=0 and hit_q=0 before the next edge.
